spi_master_sequencer: RTL and testbench

Single-line (SPI mode 0, MSB first) master that sequences complete memory transactions (command byte, address byte, N data bytes) toward `qpi_memory_slave` operating in single-line mode. It replaces hand-driven `sck`/`cs`/`mosi` stimulus with a request/handshake interface clocked by `main_clock`. It is used on the host side of loopback builds and as the bus driver in system-level benches.

---
 rtl/spi_master_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer: single-line SPI mode-0 master that issues one
// command byte, one address byte and len data bytes per accepted start.
// state    | meaning
// IDLE     | waiting for start, cs high
// CS_SETUP | cs low, sck low, before the first bit
// BIT_LOW  | sck low, mosi presents the current bit
// BIT_HIGH | sck high, miso sampled on the last cycle
// CS_HOLD  | after the last bit, cs still low
// CS_GAP   | cs high; done pulses on the final cycle, where start is accepted
module spi_master_sequencer #(
  parameter int HALF  = 5,
  parameter int LEN_W = 4
) (
  input  logic             main_clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       cmd,
  input  logic [7:0]       addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_data_ready,
  output logic [7:0]       rd_data,
  output logic             rd_data_valid,
  output logic             busy,
  output logic             done,
  output logic             sck,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int TW = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, BIT_LOW, BIT_HIGH, CS_HOLD, CS_GAP} state_t;
  typedef enum logic [1:0] {PH_CMD, PH_ADDR, PH_DATA} phase_t;

  state_t           state, state_nxt;
  phase_t           phase, phase_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]       cmd_r, cmd_nxt, addr_r, addr_nxt;
  logic             is_write, is_write_nxt;
  // shift holds the bits still to send after the one already on mosi
  logic [6:0]       shift, shift_nxt;
  logic [6:0]       rx, rx_nxt;
  logic [7:0]       rd_data_nxt;
  logic             wr_ready_nxt, rd_valid_nxt, busy_nxt, done_nxt;
  logic             sck_nxt, cs_nxt, mosi_nxt;
  logic             tm_done, accept;

  assign tm_done = (timer == '0);

  // next-state, datapath and registered-output values
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    timer_nxt    = tm_done ? timer : timer - TIMER_ONE;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    cmd_nxt      = cmd_r;
    addr_nxt     = addr_r;
    is_write_nxt = is_write;
    shift_nxt    = shift;
    rx_nxt       = rx;
    rd_data_nxt  = rd_data;
    wr_ready_nxt = 1'b0;
    rd_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    busy_nxt     = busy;
    sck_nxt      = sck;
    cs_nxt       = cs;
    mosi_nxt     = mosi;
    accept       = 1'b0;
    case (state)
      IDLE: accept = start;
      CS_SETUP: if (tm_done) begin
        state_nxt   = BIT_LOW;
        timer_nxt   = HALF_M1;
        phase_nxt   = PH_CMD;
        bit_cnt_nxt = 3'd7;
        shift_nxt   = cmd_r[6:0];
        mosi_nxt    = cmd_r[7];
      end
      BIT_LOW: if (tm_done) begin
        state_nxt = BIT_HIGH;
        timer_nxt = HALF_M1;
        sck_nxt   = 1'b1;
      end
      BIT_HIGH: if (tm_done) begin
        rx_nxt    = {rx[5:0], miso};
        sck_nxt   = 1'b0;
        timer_nxt = HALF_M1;
        state_nxt = BIT_LOW;
        if (bit_cnt != 3'd0) begin
          bit_cnt_nxt = bit_cnt - 3'd1;
          mosi_nxt    = shift[6];
          shift_nxt   = {shift[5:0], 1'b0};
        end else begin
          bit_cnt_nxt = 3'd7;
          if (phase == PH_DATA && !is_write) begin
            rd_data_nxt  = {rx, miso};
            rd_valid_nxt = 1'b1;
          end
          if (phase == PH_CMD) begin
            phase_nxt = PH_ADDR;
            shift_nxt = addr_r[6:0];
            mosi_nxt  = addr_r[7];
          end else if (byte_cnt != '0) begin
            phase_nxt    = PH_DATA;
            byte_cnt_nxt = byte_cnt - LEN_W'(1);
            if (is_write) begin
              shift_nxt    = wr_data[6:0];
              mosi_nxt     = wr_data[7];
              wr_ready_nxt = 1'b1;
            end else begin
              shift_nxt = 7'h00;
              mosi_nxt  = 1'b0;
            end
          end else begin
            state_nxt = CS_HOLD;
            mosi_nxt  = 1'b0;
          end
        end
      end
      CS_HOLD: if (tm_done) begin
        state_nxt = CS_GAP;
        timer_nxt = HALF_M1;
        cs_nxt    = 1'b1;
      end
      CS_GAP: begin
        if (timer == TIMER_ONE) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
        if (tm_done) begin
          state_nxt = IDLE;
          accept    = start;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) begin
      state_nxt    = CS_SETUP;
      timer_nxt    = HALF_M1;
      cmd_nxt      = cmd;
      addr_nxt     = addr;
      is_write_nxt = (cmd != 8'h03);
      byte_cnt_nxt = len;
      cs_nxt       = 1'b0;
      busy_nxt     = 1'b1;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge main_clock) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= PH_CMD;
      timer         <= '0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= '0;
      cmd_r         <= 8'h00;
      addr_r        <= 8'h00;
      is_write      <= 1'b0;
      shift         <= 7'h00;
      rx            <= 7'h00;
      rd_data       <= 8'h00;
      wr_data_ready <= 1'b0;
      rd_data_valid <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      sck           <= 1'b0;
      cs            <= 1'b1;
      mosi          <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      timer         <= timer_nxt;
      bit_cnt       <= bit_cnt_nxt;
      byte_cnt      <= byte_cnt_nxt;
      cmd_r         <= cmd_nxt;
      addr_r        <= addr_nxt;
      is_write      <= is_write_nxt;
      shift         <= shift_nxt;
      rx            <= rx_nxt;
      rd_data       <= rd_data_nxt;
      wr_data_ready <= wr_ready_nxt;
      rd_data_valid <= rd_valid_nxt;
      done          <= done_nxt;
      busy          <= busy_nxt;
      sck           <= sck_nxt;
      cs            <= cs_nxt;
      mosi          <= mosi_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Testbench for spi_master_sequencer: HALF=5 instance for most scenarios,
// HALF=2 instance for back-to-back transfers.
module tb_spi_master_sequencer;
  localparam int H1 = 5;
  localparam int H2 = 2;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass = 0;

  // instance 1 (HALF=5)
  logic reset, start, miso;
  logic [7:0] cmd, addr, wr_data, rd_data;
  logic [LW-1:0] len;
  logic wrr, rdv, busy, done, sck, cs, mosi;
  logic [23:0] miso_word;
  assign miso = miso_word[23];
  always @(negedge sck) miso_word = miso_word << 1;

  spi_master_sequencer #(.HALF(H1), .LEN_W(LW)) dut (
    .main_clock(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr),
    .len(len), .wr_data(wr_data), .wr_data_ready(wrr), .rd_data(rd_data),
    .rd_data_valid(rdv), .busy(busy), .done(done), .sck(sck), .cs(cs),
    .mosi(mosi), .miso(miso));

  // instance 2 (HALF=2)
  logic rst2, start2, miso2;
  logic [7:0] cmd2, addr2, wr2, rd2;
  logic [LW-1:0] len2;
  logic wrr2, rdv2, busy2, done2, sck2, cs2, mosi2;
  assign miso2 = 1'b0;

  spi_master_sequencer #(.HALF(H2), .LEN_W(LW)) dut2 (
    .main_clock(clk), .reset(rst2), .start(start2), .cmd(cmd2), .addr(addr2),
    .len(len2), .wr_data(wr2), .wr_data_ready(wrr2), .rd_data(rd2),
    .rd_data_valid(rdv2), .busy(busy2), .done(done2), .sck(sck2), .cs(cs2),
    .mosi(mosi2), .miso(miso2));

  // scoreboard: expected bytes pushed at stimulus, observed bits pushed on sck rise
  logic [7:0] exp_q[$], exp2_q[$], wr_src[$], wr2_src[$], rdv_q[$];
  logic obs_q[$], obs2_q[$];
  int wrr_q[$], done_q[$], done2_q[$], rise2_q[$], fall2_q[$];
  int hi_bad, per_bad, mosi_bad, cs_low_cnt, cs_fall_cyc, cs_rise_cyc;
  int hi_run, last_rise, first_rise;
  int hi_bad2, per_bad2, hi_run2, last_rise2;
  logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic p_sck2 = 1'b0, p_cs2 = 1'b1;

  // observation of instance 1, away from the active edge
  always @(negedge clk) begin
    if (!cs && p_cs) begin cs_fall_cyc = cyc; last_rise = -1; end
    if (cs && !p_cs) cs_rise_cyc = cyc;
    if (!cs) cs_low_cnt++;
    if (sck && !p_sck) begin
      obs_q.push_back(mosi);
      if (last_rise >= 0 && cyc - last_rise != 2 * H1) per_bad++;
      last_rise = cyc;
      if (first_rise < 0) first_rise = cyc;
    end
    if (sck) hi_run++;
    else if (p_sck) begin
      if (hi_run != H1) hi_bad++;
      hi_run = 0;
    end
    if (sck && p_sck && mosi !== p_mosi) mosi_bad++;
    if (wrr) begin
      wrr_q.push_back(cyc);
      if (wr_src.size() > 0) wr_data = wr_src.pop_front();
    end
    if (rdv) rdv_q.push_back(rd_data);
    if (done) done_q.push_back(cyc);
    p_sck = sck; p_cs = cs; p_mosi = mosi;
  end

  // observation of instance 2
  always @(negedge clk) begin
    if (!cs2 && p_cs2) begin fall2_q.push_back(cyc); last_rise2 = -1; end
    if (cs2 && !p_cs2) rise2_q.push_back(cyc);
    if (sck2 && !p_sck2) begin
      obs2_q.push_back(mosi2);
      if (last_rise2 >= 0 && cyc - last_rise2 != 2 * H2) per_bad2++;
      last_rise2 = cyc;
    end
    if (sck2) hi_run2++;
    else if (p_sck2) begin
      if (hi_run2 != H2) hi_bad2++;
      hi_run2 = 0;
    end
    if (wrr2 && wr2_src.size() > 0) wr2 = wr2_src.pop_front();
    if (done2) done2_q.push_back(cyc);
    p_sck2 = sck2; p_cs2 = cs2;
  end

  task automatic clear1();
    obs_q.delete(); exp_q.delete(); wrr_q.delete(); rdv_q.delete(); done_q.delete();
    wr_src.delete();
    hi_bad = 0; per_bad = 0; mosi_bad = 0; cs_low_cnt = 0; first_rise = -1;
  endtask

  task automatic pop_byte(input int which, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (which == 1 && obs_q.size() > 0) b = {b[6:0], obs_q.pop_front()};
      else if (which == 2 && obs2_q.size() > 0) b = {b[6:0], obs2_q.pop_front()};
      else b = {b[6:0], 1'bx};
    end
  endtask

  task automatic start_txn1(input logic [7:0] c, input logic [7:0] a, input logic [LW-1:0] l);
    cmd = c; addr = a; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs, sck, mosi, busy, done, wrr, rdv, rd_data} !== {1'b1, 6'b0, 8'h00})
      $display("FAIL reset_outputs: got %b expected %b", {cs, sck, mosi, busy, done, wrr, rdv, rd_data}, {1'b1, 6'b0, 8'h00});
    else n_pass++;
    n_checks++;
    if ({cs2, sck2, mosi2, busy2, done2} !== 5'b10000)
      $display("FAIL reset_outputs2: got %b expected %b", {cs2, sck2, mosi2, busy2, done2}, 5'b10000);
    else n_pass++;
    reset = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cs, sck, busy, done} !== 4'b1000)
      $display("FAIL idle_after_reset: got %b expected %b", {cs, sck, busy, done}, 4'b1000);
    else n_pass++;
  endtask

  task automatic test_write();
    int k, t, d;
    logic [7:0] got, exp;
    clear1();
    wr_data = 8'hCD; wr_src.push_back(8'h53);
    exp_q.push_back(8'h02); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'h53);
    start_txn1(8'h02, 8'hAB, 4'd2);
    k = cyc;
    n_checks++;
    if ({cs, busy} !== 2'b01) $display("FAIL write_accept: cs,busy got %b expected 01", {cs, busy});
    else n_pass++;
    t = 0;
    while (done_q.size() == 0 && t < 1000) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (done_q.size() != 1) $display("FAIL write_done: got %0d pulses expected 1", done_q.size());
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 32) $display("FAIL write_sck_pulses: got %0d expected 32", obs_q.size());
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      pop_byte(1, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL write_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (cs_low_cnt != 330) $display("FAIL write_cs_low: got %0d expected 330", cs_low_cnt);
    else n_pass++;
    d = (wrr_q.size() == 2) ? wrr_q[1] - wrr_q[0] : -1;
    n_checks++;
    if (d != 80) $display("FAIL write_ready_spacing: got %0d (pulses %0d) expected 80", d, wrr_q.size());
    else n_pass++;
    n_checks++;
    if (hi_bad != 0 || per_bad != 0)
      $display("FAIL write_sck_timing: bad_high %0d bad_period %0d expected 0 0", hi_bad, per_bad);
    else n_pass++;
    n_checks++;
    if (mosi_bad != 0) $display("FAIL write_mosi_stable: got %0d changes while sck high expected 0", mosi_bad);
    else n_pass++;
    n_checks++;
    if (cs_fall_cyc != k || first_rise - cs_fall_cyc != 2 * H1)
      $display("FAIL write_first_edge: cs fell %0d (want %0d), first rise %0d cycles later (want %0d)",
               cs_fall_cyc, k, first_rise - cs_fall_cyc, 2 * H1);
    else n_pass++;
  endtask

  task automatic test_read();
    int t;
    logic [7:0] got, exp;
    clear1();
    miso_word = 24'h0000AB;
    exp_q.push_back(8'h03); exp_q.push_back(8'h10); exp_q.push_back(8'h00);
    start_txn1(8'h03, 8'h10, 4'd1);
    t = 0;
    while (done_q.size() == 0 && t < 800) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (obs_q.size() != 24) $display("FAIL read_sck_pulses: got %0d expected 24", obs_q.size());
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      pop_byte(1, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL read_mosi_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (rdv_q.size() != 1 || rdv_q[0] !== 8'hAB)
      $display("FAIL read_data: got %0d valid pulses first %h expected 1 pulse of ab",
               rdv_q.size(), (rdv_q.size() > 0) ? rdv_q[0] : 8'hxx);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'hAB) $display("FAIL read_rd_data_hold: got %h expected ab", rd_data);
    else n_pass++;
    // done lands on the HALF-th cycle that cs is high
    n_checks++;
    if (done_q.size() != 1 || done_q[0] - cs_rise_cyc != H1 - 1)
      $display("FAIL read_done_gap: got %0d pulses offset %0d expected 1 pulse offset %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] - cs_rise_cyc : -1, H1 - 1);
    else n_pass++;
    n_checks++;
    if (cs_low_cnt != 250 || wrr_q.size() != 0)
      $display("FAIL read_cs_low: got %0d low cycles %0d ready pulses expected 250 0", cs_low_cnt, wrr_q.size());
    else n_pass++;
  endtask

  task automatic test_len_zero();
    int t;
    logic [7:0] got, exp;
    clear1();
    wr_data = 8'hEE;
    exp_q.push_back(8'h02); exp_q.push_back(8'h44);
    start_txn1(8'h02, 8'h44, 4'd0);
    t = 0;
    while (done_q.size() == 0 && t < 600) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (obs_q.size() != 16 || done_q.size() != 1)
      $display("FAIL len0_pulses: got %0d sck %0d done expected 16 1", obs_q.size(), done_q.size());
    else n_pass++;
    for (int b = 0; b < 2; b++) begin
      pop_byte(1, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL len0_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (wrr_q.size() != 0 || rdv_q.size() != 0 || cs_low_cnt != 170)
      $display("FAIL len0_handshake: ready %0d valid %0d cs_low %0d expected 0 0 170",
               wrr_q.size(), rdv_q.size(), cs_low_cnt);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    int t;
    logic [7:0] got, exp;
    clear1();
    wr_data = 8'hCD; wr_src.push_back(8'h53);
    exp_q.push_back(8'h02); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'h53);
    start_txn1(8'h02, 8'hAB, 4'd2);
    repeat (49) @(negedge clk);
    start_txn1(8'h03, 8'h55, 4'd0);
    t = 0;
    while (done !== 1'b1 && t < 700) begin @(negedge clk); t++; end
    exp_q.push_back(8'h02); exp_q.push_back(8'h77);
    start_txn1(8'h02, 8'h77, 4'd0);
    n_checks++;
    if ({cs, busy} !== 2'b01) $display("FAIL restart_in_done_cycle: cs,busy got %b expected 01", {cs, busy});
    else n_pass++;
    t = 0;
    while (done_q.size() < 2 && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (done_q.size() != 2 || obs_q.size() != 48)
      $display("FAIL ignored_start_counts: got %0d done %0d sck expected 2 48", done_q.size(), obs_q.size());
    else n_pass++;
    for (int b = 0; b < 6; b++) begin
      pop_byte(1, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL ignored_start_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [7:0] got, exp;
    clear1();
    wr_data = 8'hCD; wr_src.push_back(8'h53);
    start_txn1(8'h02, 8'hAB, 4'd2);
    t = 0;
    while (obs_q.size() < 11 && t < 300) begin @(negedge clk); t++; end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cs, sck, mosi, busy, done, wrr, rdv, rd_data} !== {1'b1, 6'b0, 8'h00})
      $display("FAIL mid_reset_outputs: got %b expected %b", {cs, sck, mosi, busy, done, wrr, rdv, rd_data}, {1'b1, 6'b0, 8'h00});
    else n_pass++;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done_q.size() != 0 || wrr_q.size() != 0 || rdv_q.size() != 0 || cs !== 1'b1)
      $display("FAIL mid_reset_quiet: done %0d ready %0d valid %0d cs %b expected 0 0 0 1",
               done_q.size(), wrr_q.size(), rdv_q.size(), cs);
    else n_pass++;
    clear1();
    wr_data = 8'h3C;
    exp_q.push_back(8'h02); exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
    start_txn1(8'h02, 8'h5A, 4'd1);
    t = 0;
    while (done_q.size() == 0 && t < 800) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (done_q.size() != 1 || wrr_q.size() != 1 || cs_low_cnt != 250)
      $display("FAIL post_reset_write: done %0d ready %0d cs_low %0d expected 1 1 250",
               done_q.size(), wrr_q.size(), cs_low_cnt);
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      pop_byte(1, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL post_reset_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int t, gap;
    logic [7:0] got, exp;
    hi_bad2 = 0; per_bad2 = 0;
    obs2_q.delete(); done2_q.delete(); rise2_q.delete(); fall2_q.delete(); wr2_src.delete();
    wr2 = 8'h22; wr2_src.push_back(8'h44);
    exp2_q.push_back(8'h02); exp2_q.push_back(8'h11); exp2_q.push_back(8'h22);
    cmd2 = 8'h02; addr2 = 8'h11; len2 = 4'd1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t = 0;
    while (done2 !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    exp2_q.push_back(8'h02); exp2_q.push_back(8'h33); exp2_q.push_back(8'h44);
    addr2 = 8'h33; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n_checks++;
    if ({cs2, busy2} !== 2'b01) $display("FAIL b2b_accept: cs,busy got %b expected 01", {cs2, busy2});
    else n_pass++;
    t = 0;
    while (done2_q.size() < 2 && t < 300) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (done2_q.size() != 2 || obs2_q.size() != 48)
      $display("FAIL b2b_counts: got %0d done %0d sck expected 2 48", done2_q.size(), obs2_q.size());
    else n_pass++;
    gap = (rise2_q.size() >= 1 && fall2_q.size() >= 2) ? fall2_q[1] - rise2_q[0] : -1;
    n_checks++;
    if (gap != H2) $display("FAIL b2b_cs_gap: got %0d cycles high expected %0d", gap, H2);
    else n_pass++;
    n_checks++;
    if (hi_bad2 != 0 || per_bad2 != 0)
      $display("FAIL b2b_sck_timing: bad_high %0d bad_period %0d expected 0 0", hi_bad2, per_bad2);
    else n_pass++;
    for (int b = 0; b < 6; b++) begin
      pop_byte(2, got);
      exp = exp2_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL b2b_byte%0d: got %h expected %h", b, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 8'h00; addr = 8'h00; len = '0; wr_data = 8'h00;
    miso_word = 24'h0;
    rst2 = 1'b1; start2 = 1'b0; cmd2 = 8'h00; addr2 = 8'h00; len2 = '0; wr2 = 8'h00;
    hi_bad = 0; per_bad = 0; mosi_bad = 0; cs_low_cnt = 0; cs_fall_cyc = -1; cs_rise_cyc = -1;
    hi_run = 0; last_rise = -1; first_rise = -1;
    hi_bad2 = 0; per_bad2 = 0; hi_run2 = 0; last_rise2 = -1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_len_zero();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
